// File: rtl/usb_link_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : usb_link_ctrl
//  Description : Full-speed USB link-state controller sitting between the
//                D+/D- pads and the SIE. Sequences attach by enabling the
//                D+ pullup after a settle delay. Qualifies bus reset (SE0)
//                and suspend (idle J), handles resume (K), and gates the
//                SIE. Single 48 MHz clock domain.
//  Ports       : clk48        - 48 MHz system clock
//                rst_n        - synchronous reset, active low
//                soft_detach  - 1 forces detach (pullup off), top priority
//                usb_d_p/n    - raw pad levels, sampled only
//                usb_pullup   - 1.5k D+ pullup enable
//                link_state   - 0 DETACHED, 1 POWERED, 2 RESET, 3 ACTIVE,
//                               4 SUSPENDED
//                sie_enable   - high while ACTIVE
//                in_reset     - high while RESET
//                bus_reset    - one-cycle pulse on RESET -> ACTIVE
//                suspended    - high while SUSPENDED
//                resume       - one-cycle pulse on SUSPENDED -> ACTIVE
//  Revision    : 1.0  initial release
// ============================================================================
module usb_link_ctrl #(
    parameter int ATTACH_CYCLES  = 48000,
    parameter int RESET_CYCLES   = 120,
    parameter int SUSPEND_CYCLES = 144000
) (
    input  logic       clk48,
    input  logic       rst_n,
    input  logic       soft_detach,
    input  logic       usb_d_p,
    input  logic       usb_d_n,
    output logic       usb_pullup,
    output logic [2:0] link_state,
    output logic       sie_enable,
    output logic       in_reset,
    output logic       bus_reset,
    output logic       suspended,
    output logic       resume
);

    // One shared counter width, large enough for the biggest threshold.
    localparam int c_MAX_AR = (ATTACH_CYCLES > RESET_CYCLES) ? ATTACH_CYCLES : RESET_CYCLES;
    localparam int c_MAX_P  = (c_MAX_AR > SUSPEND_CYCLES) ? c_MAX_AR : SUSPEND_CYCLES;
    localparam int c_CNT_W  = $clog2(c_MAX_P + 1);

    localparam logic [c_CNT_W-1:0] c_ATTACH_LAST  = c_CNT_W'(ATTACH_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_RESET_LAST   = c_CNT_W'(RESET_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_SUSPEND_LAST = c_CNT_W'(SUSPEND_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_DETACHED  = 3'd0,
        ST_POWERED   = 3'd1,
        ST_RESET     = 3'd2,
        ST_ACTIVE    = 3'd3,
        ST_SUSPENDED = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [c_CNT_W-1:0] attach_cnt_q, attach_cnt_d;
    logic [c_CNT_W-1:0] se0_cnt_q, se0_cnt_d;
    logic [c_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic               bus_reset_d, resume_d;

    // Two-flop pad synchronizer; resets to J so the line looks idle.
    logic dp_s1_q, dn_s1_q, dp_s2_q, dn_s2_q;

    // Registered outputs
    logic usb_pullup_q, sie_enable_q, in_reset_q, bus_reset_q, suspended_q, resume_q;

    // Line decode on the second sync stage. SE1 matches none of these.
    logic w_se0, w_j, w_k;
    assign w_se0 = ~dp_s2_q & ~dn_s2_q;
    assign w_j   =  dp_s2_q & ~dn_s2_q;
    assign w_k   = ~dp_s2_q &  dn_s2_q;

    always_comb begin
        state_d      = state_q;
        attach_cnt_d = attach_cnt_q;
        se0_cnt_d    = se0_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        bus_reset_d  = 1'b0;
        resume_d     = 1'b0;

        if (soft_detach) begin
            state_d      = ST_DETACHED;
            attach_cnt_d = '0;
            se0_cnt_d    = '0;
            idle_cnt_d   = '0;
        end else begin
            case (state_q)
                ST_DETACHED: begin
                    if (attach_cnt_q == c_ATTACH_LAST) begin
                        state_d      = ST_POWERED;
                        attach_cnt_d = '0;
                    end else begin
                        attach_cnt_d = attach_cnt_q + 1'b1;
                    end
                end

                ST_RESET: begin
                    // Reset lasts as long as the host holds SE0.
                    se0_cnt_d  = '0;
                    idle_cnt_d = '0;
                    if (!w_se0) begin
                        state_d     = ST_ACTIVE;
                        bus_reset_d = 1'b1;
                    end
                end

                default: begin
                    // POWERED, ACTIVE and SUSPENDED all qualify bus reset.
                    if (w_se0) begin
                        idle_cnt_d = '0;
                        if (se0_cnt_q == c_RESET_LAST) begin
                            state_d   = ST_RESET;
                            se0_cnt_d = '0;
                        end else begin
                            se0_cnt_d = se0_cnt_q + 1'b1;
                        end
                    end else begin
                        se0_cnt_d = '0;
                        if (state_q == ST_ACTIVE) begin
                            if (w_j) begin
                                if (idle_cnt_q == c_SUSPEND_LAST) begin
                                    state_d    = ST_SUSPENDED;
                                    idle_cnt_d = '0;
                                end else begin
                                    idle_cnt_d = idle_cnt_q + 1'b1;
                                end
                            end else begin
                                idle_cnt_d = '0;
                            end
                        end else if ((state_q == ST_SUSPENDED) && w_k) begin
                            state_d  = ST_ACTIVE;
                            resume_d = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk48) begin
        if (!rst_n) begin
            dp_s1_q      <= 1'b1;
            dn_s1_q      <= 1'b0;
            dp_s2_q      <= 1'b1;
            dn_s2_q      <= 1'b0;
            state_q      <= ST_DETACHED;
            attach_cnt_q <= '0;
            se0_cnt_q    <= '0;
            idle_cnt_q   <= '0;
            usb_pullup_q <= 1'b0;
            sie_enable_q <= 1'b0;
            in_reset_q   <= 1'b0;
            bus_reset_q  <= 1'b0;
            suspended_q  <= 1'b0;
            resume_q     <= 1'b0;
        end else begin
            dp_s1_q      <= usb_d_p;
            dn_s1_q      <= usb_d_n;
            dp_s2_q      <= dp_s1_q;
            dn_s2_q      <= dn_s1_q;
            state_q      <= state_d;
            attach_cnt_q <= attach_cnt_d;
            se0_cnt_q    <= se0_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            // Outputs follow the next state so they change on the same edge.
            usb_pullup_q <= (state_d != ST_DETACHED);
            sie_enable_q <= (state_d == ST_ACTIVE);
            in_reset_q   <= (state_d == ST_RESET);
            bus_reset_q  <= bus_reset_d;
            suspended_q  <= (state_d == ST_SUSPENDED);
            resume_q     <= resume_d;
        end
    end

    assign usb_pullup = usb_pullup_q;
    assign link_state = state_q;
    assign sie_enable = sie_enable_q;
    assign in_reset   = in_reset_q;
    assign bus_reset  = bus_reset_q;
    assign suspended  = suspended_q;
    assign resume     = resume_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_link_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_usb_link_ctrl
//  Description : Self-checking bench for usb_link_ctrl with a behavioural
//                link model driven by line run lengths.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_usb_link_ctrl;

    localparam int A = 16;
    localparam int R = 8;
    localparam int S = 32;

    logic       clk48 = 1'b0;
    logic       rst_n = 1'b0;
    logic       soft_detach = 1'b0;
    logic       usb_d_p = 1'b1;
    logic       usb_d_n = 1'b0;
    logic       usb_pullup;
    logic [2:0] link_state;
    logic       sie_enable, in_reset, bus_reset, suspended, resume;
    logic [8:0] dut_vec;

    int total = 0;
    int bad   = 0;

    // Model state: link state number, run lengths, delayed line samples
    int         m_st, m_att, m_se0, m_j;
    logic       m_br, m_rs;
    logic [1:0] m_s1, m_s2;

    always #5 clk48 = ~clk48;

    usb_link_ctrl #(
        .ATTACH_CYCLES (A),
        .RESET_CYCLES  (R),
        .SUSPEND_CYCLES(S)
    ) dut (
        .clk48      (clk48),
        .rst_n      (rst_n),
        .soft_detach(soft_detach),
        .usb_d_p    (usb_d_p),
        .usb_d_n    (usb_d_n),
        .usb_pullup (usb_pullup),
        .link_state (link_state),
        .sie_enable (sie_enable),
        .in_reset   (in_reset),
        .bus_reset  (bus_reset),
        .suspended  (suspended),
        .resume     (resume)
    );

    assign dut_vec = {usb_pullup, link_state, sie_enable, in_reset, bus_reset, suspended, resume};

    function automatic logic [8:0] m_vec();
        logic [2:0] st;
        st = 3'(m_st);
        return {(m_st != 0), st, (m_st == 3), (m_st == 2), m_br, (m_st == 4), m_rs};
    endfunction

    // Behavioural model: line seen two edges late; states change when a
    // run of a symbol reaches its threshold length.
    task automatic model_edge();
        logic [1:0] line;
        m_br = 1'b0;
        m_rs = 1'b0;
        if (!rst_n) begin
            m_st = 0; m_att = 0; m_se0 = 0; m_j = 0;
            m_s1 = 2'b10; m_s2 = 2'b10;
        end else begin
            line = m_s2;
            m_s2 = m_s1;
            m_s1 = {usb_d_p, usb_d_n};
            if (soft_detach) begin
                m_st = 0; m_att = 0; m_se0 = 0; m_j = 0;
            end else if (m_st == 0) begin
                m_att++;
                if (m_att == A) begin m_st = 1; m_att = 0; end
            end else if (m_st == 2) begin
                if (line != 2'b00) begin m_st = 3; m_br = 1'b1; end
            end else if (line == 2'b00) begin
                m_se0++;
                m_j = 0;
                if (m_se0 == R) begin m_st = 2; m_se0 = 0; end
            end else begin
                m_se0 = 0;
                if (m_st == 3) begin
                    if (line == 2'b10) begin
                        m_j++;
                        if (m_j == S) begin m_st = 4; m_j = 0; end
                    end else begin
                        m_j = 0;
                    end
                end else if (m_st == 4 && line == 2'b01) begin
                    m_st = 3;
                    m_rs = 1'b1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk48);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic p, input logic n, input int cyc);
        usb_d_p = p;
        usb_d_n = n;
        repeat (cyc) step();
    endtask

    task automatic test_reset();
        int  n;
        bit  seen;
        rst_n = 1'b0; soft_detach = 1'b0;
        drive(1'b1, 1'b0, 2);
        total++;
        if (dut_vec !== 9'd0) begin
            bad++; $display("FAIL reset_outputs got=%b want=%b", dut_vec, 9'd0);
        end
        rst_n = 1'b1;
        n = 0; seen = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            step();
            if (usb_pullup === 1'b1) begin seen = 1; n = i; end
        end
        total++;
        if (!seen || n != A) begin
            bad++; $display("FAIL attach_latency got=%0d want=%0d", n, A);
        end
        total++;
        if (link_state !== 3'd1 || dut_vec !== m_vec()) begin
            bad++; $display("FAIL attach_state got=%b want=%b", dut_vec, m_vec());
        end
    endtask

    task automatic test_reset_qualify();
        int n, pulses;
        drive(1'b0, 1'b0, 7);
        drive(1'b1, 1'b0, 5);
        total++;
        if (link_state !== 3'd1 || dut_vec !== m_vec()) begin
            bad++; $display("FAIL short_se0 got=%b want=%b", dut_vec, m_vec());
        end
        usb_d_p = 1'b0; usb_d_n = 1'b0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (in_reset === 1'b1 && n == 0) n = i;
        end
        total++;
        if (n != 2 + R) begin
            bad++; $display("FAIL reset_latency got=%0d want=%0d", n, 2 + R);
        end
        usb_d_p = 1'b1; usb_d_n = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus_reset === 1'b1) pulses++;
        end
        total++;
        if (pulses != 1 || link_state !== 3'd3 || sie_enable !== 1'b1) begin
            bad++; $display("FAIL bus_reset_exit got pulses=%0d state=%0d want pulses=1 state=3", pulses, link_state);
        end
    endtask

    task automatic test_suspend();
        int n, pulses;
        drive(1'b0, 1'b1, 3);
        drive(1'b1, 1'b0, S - 1);
        drive(1'b0, 1'b1, 3);
        total++;
        if (link_state !== 3'd3 || suspended !== 1'b0 || dut_vec !== m_vec()) begin
            bad++; $display("FAIL idle_short got=%b want=%b", dut_vec, m_vec());
        end
        usb_d_p = 1'b1; usb_d_n = 1'b0;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (suspended === 1'b1 && n == 0) n = i;
        end
        total++;
        if (n != 2 + S) begin
            bad++; $display("FAIL suspend_latency got=%0d want=%0d", n, 2 + S);
        end
        drive(1'b0, 1'b1, 1);
        usb_d_p = 1'b1; usb_d_n = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (resume === 1'b1) pulses++;
        end
        total++;
        if (pulses != 1 || link_state !== 3'd3 || dut_vec !== m_vec()) begin
            bad++; $display("FAIL resume got pulses=%0d state=%0d want pulses=1 state=3", pulses, link_state);
        end
    endtask

    task automatic test_suspend_reset();
        int rs, br;
        drive(1'b1, 1'b0, 40);
        total++;
        if (suspended !== 1'b1 || link_state !== 3'd4) begin
            bad++; $display("FAIL suspend_enter got=%0d want=4", link_state);
        end
        usb_d_p = 1'b0; usb_d_n = 1'b0;
        rs = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (resume === 1'b1) rs++;
        end
        total++;
        if (rs != 0 || link_state !== 3'd2) begin
            bad++; $display("FAIL suspend_to_reset got state=%0d resume=%0d want state=2 resume=0", link_state, rs);
        end
        usb_d_p = 1'b1; usb_d_n = 1'b0;
        br = 0; rs = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus_reset === 1'b1) br++;
            if (resume === 1'b1) rs++;
        end
        total++;
        if (br != 1 || rs != 0 || link_state !== 3'd3) begin
            bad++; $display("FAIL reset_from_suspend got br=%0d rs=%0d state=%0d want 1 0 3", br, rs, link_state);
        end
    endtask

    task automatic test_detach();
        int n;
        drive(1'b0, 1'b0, 10);
        total++;
        if (in_reset !== 1'b1) begin
            bad++; $display("FAIL detach_pre_reset got=%b want=1", in_reset);
        end
        soft_detach = 1'b1;
        step();
        total++;
        if (dut_vec !== 9'd0) begin
            bad++; $display("FAIL detach_in_reset got=%b want=%b", dut_vec, 9'd0);
        end
        soft_detach = 1'b0;
        usb_d_p = 1'b1; usb_d_n = 1'b0;
        n = 0;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            step();
            if (usb_pullup === 1'b1) n = i;
        end
        total++;
        if (n != A) begin
            bad++; $display("FAIL reattach_latency got=%0d want=%0d", n, A);
        end
        drive(1'b0, 1'b0, 10);
        drive(1'b1, 1'b0, 4);
        total++;
        if (link_state !== 3'd3) begin
            bad++; $display("FAIL detach_pre_active got=%0d want=3", link_state);
        end
        soft_detach = 1'b1;
        step();
        total++;
        if (dut_vec !== 9'd0) begin
            bad++; $display("FAIL detach_in_active got=%b want=%b", dut_vec, 9'd0);
        end
        soft_detach = 1'b0;
        drive(1'b1, 1'b0, A);
        total++;
        if (usb_pullup !== 1'b1 || dut_vec !== m_vec()) begin
            bad++; $display("FAIL reattach2 got=%b want=%b", dut_vec, m_vec());
        end
    endtask

    task automatic test_rst_suspended();
        int n, err;
        drive(1'b0, 1'b0, 10);
        drive(1'b1, 1'b0, 40);
        total++;
        if (link_state !== 3'd4) begin
            bad++; $display("FAIL pre_rst_suspend got=%0d want=4", link_state);
        end
        rst_n = 1'b0;
        step();
        total++;
        if (dut_vec !== 9'd0) begin
            bad++; $display("FAIL rst_in_suspend got=%b want=%b", dut_vec, 9'd0);
        end
        rst_n = 1'b1;
        n = 0;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            step();
            if (usb_pullup === 1'b1) n = i;
        end
        total++;
        if (n != A) begin
            bad++; $display("FAIL rst_reattach got=%0d want=%0d", n, A);
        end
        drive(1'b0, 1'b0, 10);
        drive(1'b1, 1'b0, 3);
        usb_d_p = 1'b1; usb_d_n = 1'b1;
        err = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (link_state !== 3'd3 || suspended !== 1'b0 || in_reset !== 1'b0) err++;
        end
        total++;
        if (err != 0) begin
            bad++; $display("FAIL se1_hold got bad_cycles=%0d want=0", err);
        end
    endtask

    task automatic test_random();
        int sym, len, mis, both;
        mis = 0; both = 0;
        for (int run = 0; run < 250; run++) begin
            sym = $urandom_range(0, 9);
            if (sym <= 2)      begin usb_d_p = 1'b0; usb_d_n = 1'b0; len = $urandom_range(1, 12); end
            else if (sym <= 6) begin usb_d_p = 1'b1; usb_d_n = 1'b0; len = $urandom_range(1, 45); end
            else if (sym <= 8) begin usb_d_p = 1'b0; usb_d_n = 1'b1; len = $urandom_range(1, 3); end
            else               begin usb_d_p = 1'b1; usb_d_n = 1'b1; len = $urandom_range(1, 4); end
            soft_detach = ($urandom_range(0, 30) == 0);
            for (int c = 0; c < len; c++) begin
                step();
                total++;
                if (dut_vec !== m_vec()) begin
                    bad++; mis++;
                    if (mis <= 5) $display("FAIL random_cycle got=%b want=%b", dut_vec, m_vec());
                end
                total++;
                if ((bus_reset & resume) !== 1'b0) begin
                    bad++; both++;
                    if (both <= 5) $display("FAIL pulse_overlap got=%b want=0", bus_reset & resume);
                end
            end
        end
        soft_detach = 1'b0;
    endtask

    initial begin
        test_reset();
        test_reset_qualify();
        test_suspend();
        test_suspend_reset();
        test_detach();
        test_rst_suspended();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
